hsem_task_disp: RTL and testbench



---
 rtl/hsem_task_disp_pkg.sv | 15 +
 rtl/hsem_task_disp_rr_pick.sv | 33 +++
 rtl/hsem_task_disp.sv | 130 +++++++++++++
 tb/tb_hsem_task_disp.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hsem_task_disp_pkg.sv
// Shared widths and FSM encoding for the task dispatcher.
// Imported by the dispatcher top and its round-robin picker.
package hsem_task_disp_pkg;

  localparam int TASK_SWITCH_WIDTH = 32;
  localparam int AHB_DATA_WIDTH    = 32;
  localparam int TASK_ID_WIDTH     = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

endpackage

// File: rtl/hsem_task_disp_rr_pick.sv
// Combinational round-robin picker: rotate, lowest set bit, un-rotate.
// Scanning starts at 'start' and wraps modulo W.
module hsem_rr_pick
  import hsem_task_disp_pkg::*;
#(
  parameter int W  = TASK_SWITCH_WIDTH,
  parameter int IW = TASK_ID_WIDTH
) (
  input  logic [W-1:0]  mask,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  localparam logic [IW:0] WRAP = (IW+1)'(W);

  logic [W-1:0]  rot;
  logic [IW-1:0] off;
  logic [IW:0]   sum;

  always_comb begin
    rot   = W'({mask, mask} >> start);
    found = |rot;
    off   = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
    sum = {1'b0, off} + {1'b0, start};
    if (sum >= WRAP) sum = sum - WRAP;
    idx = sum[IW-1:0];
  end

endmodule

// File: rtl/hsem_task_disp.sv
// Core-side task dispatcher: issues pending tasks round-robin over
// valid/ready, tracks done/error masks with clear-on-read and an irq.
module hsem_task_disp
  import hsem_task_disp_pkg::*;
#(
  parameter int TASK_WIDTH = TASK_SWITCH_WIDTH,
  parameter int ID_WIDTH   = TASK_ID_WIDTH,
  parameter int DATA_WIDTH = AHB_DATA_WIDTH
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  tsk_load,
  input  logic [TASK_WIDTH-1:0] tsk_stat,
  output logic                  task_valid,
  output logic [ID_WIDTH-1:0]   task_id,
  input  logic                  task_ready,
  input  logic                  task_done,
  input  logic                  task_err,
  input  logic                  rd_sel,
  input  logic                  rd_clr,
  output logic [DATA_WIDTH-1:0] ohrdata,
  output logic                  busy,
  output logic                  irq
);

  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(TASK_WIDTH - 1);

  state_e                state_q, state_d;
  logic [TASK_WIDTH-1:0] pending_q, pending_d;
  logic [TASK_WIDTH-1:0] done_q, done_d;
  logic [TASK_WIDTH-1:0] err_q, err_d;
  logic [ID_WIDTH-1:0]   last_id_q, last_id_d;
  logic [ID_WIDTH-1:0]   task_id_q, task_id_d;
  logic                  irq_q, irq_d;

  logic [ID_WIDTH-1:0]   scan_start;
  logic                  pick_found;
  logic [ID_WIDTH-1:0]   pick_idx;
  logic                  done_set;

  assign scan_start = (last_id_q == LAST_ID) ? '0 : last_id_q + 1'b1;

  hsem_rr_pick #(
    .W  (TASK_WIDTH),
    .IW (ID_WIDTH)
  ) u_pick (
    .mask  (pending_q),
    .start (scan_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    done_d    = done_q;
    err_d     = err_q;
    last_id_d = last_id_q;
    task_id_d = task_id_q;
    done_set  = 1'b0;
    irq_d     = |done_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          task_id_d           = pick_idx;
          last_id_d           = pick_idx;
          pending_d[pick_idx] = 1'b0;
          state_d             = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (task_ready) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (task_done) begin
          done_set = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new load overrides the pick: set re-queues, zero aborts all
    if (tsk_load) begin
      if (tsk_stat != '0) pending_d = pending_d | tsk_stat;
      else                pending_d = '0;
    end

    if (rd_clr) begin
      done_d = '0;
      err_d  = '0;
    end
    if (done_set) begin
      done_d[task_id_q] = 1'b1;
      if (task_err) err_d[task_id_q] = 1'b1;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      done_q    <= '0;
      err_q     <= '0;
      last_id_q <= LAST_ID;
      task_id_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      err_q     <= err_d;
      last_id_q <= last_id_d;
      task_id_q <= task_id_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    ohrdata                   = '0;
    ohrdata[TASK_WIDTH-1:0]   = rd_sel ? err_q : done_q;
  end

  assign task_valid = (state_q == ST_ISSUE);
  assign task_id    = task_id_q;
  assign busy       = (state_q != ST_IDLE) || (pending_q != '0);
  assign irq        = irq_q;

endmodule

// File: tb/tb_hsem_task_disp.sv
// Scoreboard bench: expected task IDs queued at load time, popped by
// a handshake monitor; mask/irq/busy checked directly by stimulus.
module tb_hsem_task_disp;

  logic        hclk;
  logic        hreset;
  logic        tsk_load;
  logic [31:0] tsk_stat;
  logic        task_valid;
  logic [4:0]  task_id;
  logic        task_ready;
  logic        task_done;
  logic        task_err;
  logic        rd_sel;
  logic        rd_clr;
  logic [31:0] ohrdata;
  logic        busy;
  logic        irq;

  int checks;
  int failures;
  logic [4:0] exp_q[$];

  hsem_task_disp dut (
    .hclk       (hclk),
    .hreset     (hreset),
    .tsk_load   (tsk_load),
    .tsk_stat   (tsk_stat),
    .task_valid (task_valid),
    .task_id    (task_id),
    .task_ready (task_ready),
    .task_done  (task_done),
    .task_err   (task_err),
    .rd_sel     (rd_sel),
    .rd_clr     (rd_clr),
    .ohrdata    (ohrdata),
    .busy       (busy),
    .irq        (irq)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic load(input logic [31:0] v);
    tsk_load = 1'b1;
    tsk_stat = v;
    tick();
    tsk_load = 1'b0;
    tsk_stat = '0;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20 && !task_valid; i++) tick();
    chk("issue_timeout", {31'd0, task_valid}, 32'd1);
  endtask

  task automatic serve(input bit err, input bit clr);
    wait_valid();
    task_ready = 1'b1;
    tick();
    task_ready = 1'b0;
    chk("valid_drop", {31'd0, task_valid}, 32'd0);
    task_done = 1'b1;
    task_err  = err;
    rd_clr    = clr;
    tick();
    task_done = 1'b0;
    task_err  = 1'b0;
    rd_clr    = 1'b0;
  endtask

  task automatic clear();
    rd_clr = 1'b1;
    tick();
    rd_clr = 1'b0;
  endtask

  always @(negedge hclk) begin
    if (!hreset && task_valid && task_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_issue actual=%0d required=none", task_id);
      end else begin
        chk("task_id", {27'd0, task_id}, {27'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    checks = 0;
    failures = 0;
    hreset = 1'b1;
    tsk_load = 1'b0;
    tsk_stat = '0;
    task_ready = 1'b0;
    task_done = 1'b0;
    task_err = 1'b0;
    rd_sel = 1'b0;
    rd_clr = 1'b0;
    tick();
    tick();
    chk("rst_valid", {31'd0, task_valid}, 32'd0);
    chk("rst_id", {27'd0, task_id}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", ohrdata, 32'd0);
    hreset = 1'b0;
    tick();

    // basic issue 0, 2
    exp_q.push_back(5'd0);
    exp_q.push_back(5'd2);
    load(32'h5);
    chk("load_no_valid", {31'd0, task_valid}, 32'd0);
    serve(1'b0, 1'b0);
    serve(1'b0, 1'b0);
    chk("basic_done", ohrdata, 32'h5);
    tick();
    chk("basic_irq", {31'd0, irq}, 32'd1);
    clear();
    chk("clr_done", ohrdata, 32'h0);
    tick();
    chk("clr_irq", {31'd0, irq}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // round-robin wrap
    exp_q.push_back(5'd30);
    load(32'h4000_0000);
    serve(1'b0, 1'b0);
    exp_q.push_back(5'd31);
    exp_q.push_back(5'd0);
    exp_q.push_back(5'd1);
    load(32'h8000_0003);
    serve(1'b0, 1'b0);
    serve(1'b0, 1'b0);
    serve(1'b0, 1'b0);
    chk("wrap_done", ohrdata, 32'hC000_0003);
    clear();

    // backpressure with ignored done pulses
    exp_q.push_back(5'd8);
    load(32'h100);
    tick();
    for (int i = 0; i < 10; i++) begin
      task_done = (i == 3 || i == 4);
      tick();
      chk("bp_valid", {31'd0, task_valid}, 32'd1);
      chk("bp_id", {27'd0, task_id}, 32'd8);
    end
    task_done = 1'b0;
    chk("bp_done_ignored", ohrdata, 32'h0);
    serve(1'b0, 1'b0);
    chk("bp_done", ohrdata, 32'h100);
    clear();

    // error path
    exp_q.push_back(5'd4);
    load(32'h10);
    serve(1'b1, 1'b0);
    rd_sel = 1'b1;
    #1;
    chk("err_mask", ohrdata, 32'h10);
    rd_sel = 1'b0;
    #1;
    chk("err_done", ohrdata, 32'h10);
    clear();

    hreset = 1'b1;
    tick();
    hreset = 1'b0;

    // abort while task 4 runs
    exp_q.push_back(5'd4);
    load(32'hF0);
    wait_valid();
    task_ready = 1'b1;
    tick();
    task_ready = 1'b0;
    load(32'h0);
    task_done = 1'b1;
    tick();
    task_done = 1'b0;
    chk("abort_done", ohrdata, 32'h10);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    tick();
    tick();
    tick();
    chk("abort_no_issue", {31'd0, task_valid}, 32'd0);

    // abort in the same cycle as a pick
    exp_q.push_back(5'd0);
    load(32'h3);
    load(32'h0);
    chk("pick_abort_busy", {31'd0, busy}, 32'd1);
    serve(1'b0, 1'b0);
    chk("pick_abort_idle", {31'd0, busy}, 32'd0);
    chk("pick_abort_done", ohrdata, 32'h11);

    // set wins over the same-cycle pick
    exp_q.push_back(5'd2);
    exp_q.push_back(5'd2);
    load(32'h4);
    load(32'h4);
    serve(1'b0, 1'b0);
    serve(1'b0, 1'b0);
    chk("requeue_done", ohrdata, 32'h15);
    chk("requeue_busy", {31'd0, busy}, 32'd0);

    // rd_clr together with task_done on task 1
    exp_q.push_back(5'd1);
    load(32'h2);
    serve(1'b0, 1'b1);
    chk("clr_collide", ohrdata, 32'h2);

    // reset mid-ISSUE
    load(32'h8);
    tick();
    chk("pre_rst_valid", {31'd0, task_valid}, 32'd1);
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
    chk("mid_rst_valid", {31'd0, task_valid}, 32'd0);
    chk("mid_rst_done", ohrdata, 32'h0);
    rd_sel = 1'b1;
    #1;
    chk("mid_rst_err", ohrdata, 32'h0);
    rd_sel = 1'b0;
    task_done = 1'b1;
    tick();
    task_done = 1'b0;
    chk("stale_done", ohrdata, 32'h0);
    tick();
    chk("stale_irq", {31'd0, irq}, 32'd0);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
